// File: rtl/common_pkg.sv
// Shared data-bus types used by the memory stage and the bus fabric.
// No logic, types only.
// No flow control of its own; the handshake is valid / data_ok.
package common;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef logic [7:0] strobe_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    strobe_t     strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

// File: rtl/pipes_pkg.sv
// Pipeline-register types between execute, memory and writeback, plus
// small decode helpers for memory-class ops.
// Types only; MEM_MISALIGN_TRAP_EN adds a misalign flag to control_t.
package pipes;
  import common::*;

  typedef enum logic [3:0] {
    OP_ALU = 4'd0,
    OP_LB  = 4'd1,
    OP_LH  = 4'd2,
    OP_LW  = 4'd3,
    OP_LD  = 4'd4,
    OP_LBU = 4'd5,
    OP_LHU = 4'd6,
    OP_LWU = 4'd7,
    OP_SB  = 4'd8,
    OP_SH  = 4'd9,
    OP_SW  = 4'd10,
    OP_SD  = 4'd11
  } op_t;

  // How a load result is widened to 64 bits.
  typedef enum logic [2:0] {
    EXT_B  = 3'd0,
    EXT_H  = 3'd1,
    EXT_W  = 3'd2,
    EXT_D  = 3'd3,
    EXT_BU = 3'd4,
    EXT_HU = 3'd5,
    EXT_WU = 3'd6
  } ext_t;

  typedef struct packed {
    op_t  op;
    logic regwrite;
`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign;
`endif
  } control_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] instr;
    control_t    ctl;
    logic [4:0]  dst;
    logic [63:0] rd2;
    logic [63:0] result;
  } excute_data_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] instr;
    control_t    ctl;
    logic [4:0]  dst;
    logic [63:0] result;
  } memory_data_t;

  function automatic logic is_load(op_t op);
    return (op >= OP_LB) && (op <= OP_LWU);
  endfunction

  function automatic logic is_store(op_t op);
    return (op >= OP_SB) && (op <= OP_SD);
  endfunction

  function automatic msize_t op_size(op_t op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return MSIZE1;
      OP_LH, OP_LHU, OP_SH: return MSIZE2;
      OP_LW, OP_LWU, OP_SW: return MSIZE4;
      default:              return MSIZE8;
    endcase
  endfunction

  function automatic ext_t op_ext(op_t op);
    case (op)
      OP_LB:   return EXT_B;
      OP_LH:   return EXT_H;
      OP_LW:   return EXT_W;
      OP_LBU:  return EXT_BU;
      OP_LHU:  return EXT_HU;
      OP_LWU:  return EXT_WU;
      default: return EXT_D;
    endcase
  endfunction

  function automatic strobe_t size_mask(msize_t s);
    case (s)
      MSIZE1:  return 8'h01;
      MSIZE2:  return 8'h03;
      MSIZE4:  return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic is_aligned(msize_t s, logic [2:0] off);
    case (s)
      MSIZE1:  return 1'b1;
      MSIZE2:  return off[0] == 1'b0;
      MSIZE4:  return off[1:0] == 2'b00;
      default: return off == 3'b000;
    endcase
  endfunction

  // Copy the execute record into the writeback record, result unchanged.
  function automatic memory_data_t to_mem(excute_data_t e);
    memory_data_t m;
    m.valid  = e.valid;
    m.pc     = e.pc;
    m.instr  = e.instr;
    m.ctl    = e.ctl;
    m.dst    = e.dst;
    m.result = e.result;
    return m;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering: store strobe/data shift and load shift/extension.
// Purely combinational, zero latency.
// No backpressure; outputs follow inputs.
// Ports: offset (addr[2:0]), size, store_in -> strobe/store_out;
//        ext, load_in -> load_out.
module mem_align
  import common::*;
  import pipes::*;
(
  input  logic [2:0]  offset,
  input  msize_t      size,
  input  logic [63:0] store_in,
  output strobe_t     strobe,
  output logic [63:0] store_out,
  input  ext_t        ext,
  input  logic [63:0] load_in,
  output logic [63:0] load_out
);

  logic [5:0]  bit_sh;
  logic [63:0] raw;

  assign bit_sh    = {offset, 3'b000};
  // Lanes shifted past byte 7 fall off the top; misaligned wraps are truncated.
  assign strobe    = size_mask(size) << offset;
  assign store_out = store_in << bit_sh;
  assign raw       = load_in >> bit_sh;

  always_comb begin
    load_out = raw;
    case (ext)
      EXT_B:   load_out = {{56{raw[7]}},  raw[7:0]};
      EXT_H:   load_out = {{48{raw[15]}}, raw[15:0]};
      EXT_W:   load_out = {{32{raw[31]}}, raw[31:0]};
      EXT_BU:  load_out = {56'd0, raw[7:0]};
      EXT_HU:  load_out = {48'd0, raw[15:0]};
      EXT_WU:  load_out = {32'd0, raw[31:0]};
      default: load_out = raw;
    endcase
  end

endmodule

// File: rtl/memory.sv
// Memory pipeline stage: issues one load/store on the data bus, registers dataM.
// Latency: pass-through 1 cycle; memory op 1 + N cycles until data_ok (min 2).
// Backpressure: stopm holds execute while an access is being set up or awaited.
// Ports: clk, reset (async, high); dataE in; dreq/dresp data bus; dataM out; stopm.
// Build option: MEM_MISALIGN_TRAP_EN traps unaligned accesses instead of issuing.
module memory
  import common::*;
  import pipes::*;
(
  input  logic         clk,
  input  logic         reset,
  input  excute_data_t dataE,
  output dbus_req_t    dreq,
  input  dbus_resp_t   dresp,
  output memory_data_t dataM,
  output logic         stopm
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, next_state;

  logic [63:0]  lat_addr;
  msize_t       lat_size;
  strobe_t      lat_strobe;
  logic [63:0]  lat_wdata;
  ext_t         lat_ext;
  logic         lat_load;

  logic         mem_op;
  logic         capture;
  memory_data_t dataM_d;

  logic [2:0]   align_off;
  strobe_t      align_strobe;
  logic [63:0]  align_wdata;
  logic [63:0]  align_rdata;

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = !is_aligned(op_size(dataE.ctl.op), dataE.result[2:0]);
`endif

  assign mem_op = dataE.valid && (is_load(dataE.ctl.op) || is_store(dataE.ctl.op));

  // Store lanes are computed from the incoming address while IDLE; load
  // extension uses the latched offset while BUSY. One aligner serves both.
  assign align_off = (state == BUSY) ? lat_addr[2:0] : dataE.result[2:0];

  mem_align u_align (
    .offset    (align_off),
    .size      (op_size(dataE.ctl.op)),
    .store_in  (dataE.rd2),
    .strobe    (align_strobe),
    .store_out (align_wdata),
    .ext       (lat_ext),
    .load_in   (dresp.data),
    .load_out  (align_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    stopm      = 1'b0;
    capture    = 1'b0;
    dataM_d    = '0;
    case (state)
      IDLE: begin
`ifdef MEM_MISALIGN_TRAP_EN
        if (mem_op && !misalign) begin
`else
        if (mem_op) begin
`endif
          next_state = BUSY;
          stopm      = 1'b1;
          capture    = 1'b1;
        end else begin
          dataM_d = to_mem(dataE);
`ifdef MEM_MISALIGN_TRAP_EN
          if (mem_op) dataM_d.ctl.misalign = 1'b1;
`endif
        end
      end
      BUSY: begin
        if (dresp.data_ok) begin
          next_state    = IDLE;
          dataM_d       = to_mem(dataE);
          dataM_d.valid = 1'b1;
          if (lat_load) dataM_d.result = align_rdata;
        end else begin
          stopm = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_addr   <= '0;
      lat_size   <= MSIZE1;
      lat_strobe <= '0;
      lat_wdata  <= '0;
      lat_ext    <= EXT_B;
      lat_load   <= 1'b0;
      dataM      <= '0;
    end else begin
      dataM <= dataM_d;
      if (capture) begin
        lat_addr   <= dataE.result;
        lat_size   <= op_size(dataE.ctl.op);
        lat_ext    <= op_ext(dataE.ctl.op);
        lat_load   <= is_load(dataE.ctl.op);
        lat_strobe <= is_load(dataE.ctl.op) ? 8'h00 : align_strobe;
        lat_wdata  <= is_load(dataE.ctl.op) ? 64'd0 : align_wdata;
      end
    end
  end

  // Request is only visible while BUSY so idle fields read as zero.
  always_comb begin
    dreq = '0;
    if (state == BUSY) begin
      dreq.valid  = 1'b1;
      dreq.addr   = lat_addr;
      dreq.size   = lat_size;
      dreq.strobe = lat_strobe;
      dreq.data   = lat_wdata;
    end
  end

endmodule

// File: tb/tb_memory.sv
module tb_memory;
  import common::*;
  import pipes::*;

  logic         clk = 1'b0;
  logic         reset;
  excute_data_t dataE;
  dbus_req_t    dreq;
  dbus_resp_t   dresp;
  memory_data_t dataM;
  logic         stopm;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  memory dut (
    .clk   (clk),
    .reset (reset),
    .dataE (dataE),
    .dreq  (dreq),
    .dresp (dresp),
    .dataM (dataM),
    .stopm (stopm)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
  endtask

  // ---------------- reference model (byte-level, from the rules) -------------
  function automatic int nbytes(op_t op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_LWU, OP_SW: return 4;
      default:              return 8;
    endcase
  endfunction

  function automatic msize_t ref_size(op_t op);
    int n = nbytes(op);
    return (n == 1) ? MSIZE1 : (n == 2) ? MSIZE2 : (n == 4) ? MSIZE4 : MSIZE8;
  endfunction

  function automatic bit ref_is_load(op_t op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU};
  endfunction

  function automatic logic [63:0] ref_load(op_t op, int off, logic [63:0] d);
    int n = nbytes(op);
    logic [63:0] v = '0;
    bit sgn = op inside {OP_LB, OP_LH, OP_LW};
    for (int i = 0; i < n; i++)
      if (off + i < 8) v[8*i +: 8] = d[8*(off+i) +: 8];
    if (sgn && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
    return v;
  endfunction

  function automatic logic [7:0] ref_strobe(op_t op, int off);
    logic [7:0] s = '0;
    for (int i = 0; i < 8; i++)
      if (i >= off && i < off + nbytes(op)) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] ref_wdata(logic [63:0] rd2, int off);
    logic [63:0] w = '0;
    for (int i = 0; i < 8; i++)
      if (i >= off) w[8*i +: 8] = rd2[8*(i-off) +: 8];
    return w;
  endfunction

  // ---------------- one complete load/store transaction ----------------------
  task automatic mem_op(input string nm, input op_t op, input logic [63:0] addr,
                        input logic [63:0] rd2, input logic [63:0] rdata, input int nwait,
                        input logic [63:0] exp_res, input logic [7:0] exp_strb,
                        input logic [63:0] exp_wdata, input msize_t exp_size);
    @(posedge clk); #1;
    dataE              = '0;
    dataE.valid        = 1'b1;
    dataE.ctl.op       = op;
    dataE.ctl.regwrite = ref_is_load(op);
    dataE.pc           = {32'h8000_0000, addr[31:0]};
    dataE.dst          = addr[4:0];
    dataE.result       = addr;
    dataE.rd2          = rd2;
    dresp              = '0;
    @(negedge clk);
    chk({nm, " stopm_accept"}, 64'(stopm), 64'd1);
    chk({nm, " dreq_idle"}, 64'(dreq.valid), 64'd0);
    for (int w = 0; w <= nwait; w++) begin
      @(posedge clk); #1;
      dresp.data_ok = (w == nwait);
      dresp.data    = (w == nwait) ? rdata : {$urandom, $urandom};
      @(negedge clk);
      chk({nm, " dreq_valid"}, 64'(dreq.valid), 64'd1);
      chk({nm, " dreq_addr"}, dreq.addr, addr);
      chk({nm, " dreq_size"}, 64'(dreq.size), 64'(exp_size));
      chk({nm, " dreq_strobe"}, 64'(dreq.strobe), 64'(exp_strb));
      if (!ref_is_load(op)) chk({nm, " dreq_data"}, dreq.data, exp_wdata);
      chk({nm, " stopm_busy"}, 64'(stopm), (w == nwait) ? 64'd0 : 64'd1);
      if (w < nwait) chk({nm, " dataM_wait"}, 64'(dataM.valid), 64'd0);
    end
    @(posedge clk); #1;
    dataE.valid = 1'b0;
    dresp       = '0;
    chk({nm, " dataM_valid"}, 64'(dataM.valid), 64'd1);
    chk({nm, " dataM_result"}, dataM.result, exp_res);
    chk({nm, " dataM_pc"}, dataM.pc, {32'h8000_0000, addr[31:0]});
    chk({nm, " dreq_after"}, 64'(dreq.valid), 64'd0);
  endtask

  typedef struct {
    string       nm;
    op_t         op;
    logic [63:0] addr;
    logic [63:0] rd2;
    logic [63:0] rdata;
    int          nwait;
    logic [63:0] exp_res;
    logic [7:0]  exp_strb;
    logic [63:0] exp_wdata;
    msize_t      exp_size;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, op_t op, logic [63:0] addr, logic [63:0] rd2,
                              logic [63:0] rdata, int nwait, logic [63:0] res,
                              logic [7:0] strb, logic [63:0] wd, msize_t sz);
    vec_t v;
    v.nm = nm; v.op = op; v.addr = addr; v.rd2 = rd2; v.rdata = rdata; v.nwait = nwait;
    v.exp_res = res; v.exp_strb = strb; v.exp_wdata = wd; v.exp_size = sz;
    return v;
  endfunction

  op_t ops[12] = '{OP_ALU, OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
                   OP_SB, OP_SH, OP_SW, OP_SD};

  initial begin
    reset = 1'b1;
    dataE = '0;
    dresp = '0;

    vecs.push_back(mk("sb_1003", OP_SB, 64'h1003, 64'hAB, 64'h0, 0,
                      64'h1003, 8'h08, 64'hAB00_0000, MSIZE1));
    vecs.push_back(mk("lb_2001", OP_LB, 64'h2001, 64'h0, 64'h8000, 3,
                      64'hFFFF_FFFF_FFFF_FF80, 8'h00, 64'h0, MSIZE1));
    vecs.push_back(mk("lbu_2001", OP_LBU, 64'h2001, 64'h0, 64'h8000, 3,
                      64'h80, 8'h00, 64'h0, MSIZE1));
    vecs.push_back(mk("lw_3004", OP_LW, 64'h3004, 64'h0, 64'h8000_0001_0000_0000, 1,
                      64'hFFFF_FFFF_8000_0001, 8'h00, 64'h0, MSIZE4));
    vecs.push_back(mk("lwu_3004", OP_LWU, 64'h3004, 64'h0, 64'h8000_0001_0000_0000, 1,
                      64'h8000_0001, 8'h00, 64'h0, MSIZE4));
    vecs.push_back(mk("sd_5000", OP_SD, 64'h5000, 64'h0123_4567_89AB_CDEF, 64'h0, 2,
                      64'h5000, 8'hFF, 64'h0123_4567_89AB_CDEF, MSIZE8));
    vecs.push_back(mk("ld_6000", OP_LD, 64'h6000, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 0,
                      64'hDEAD_BEEF_CAFE_F00D, 8'h00, 64'h0, MSIZE8));
    vecs.push_back(mk("sh_7006", OP_SH, 64'h7006, 64'hBEEF, 64'h0, 1,
                      64'h7006, 8'hC0, 64'hBEEF_0000_0000_0000, MSIZE2));
    vecs.push_back(mk("lhu_7006", OP_LHU, 64'h7006, 64'h0, 64'h1234_0000_0000_0000, 0,
                      64'h1234, 8'h00, 64'h0, MSIZE2));
    vecs.push_back(mk("lh_7002", OP_LH, 64'h7002, 64'h0, 64'h0000_0000_8765_0000, 2,
                      64'hFFFF_FFFF_FFFF_8765, 8'h00, 64'h0, MSIZE2));
`ifndef MEM_MISALIGN_TRAP_EN
    vecs.push_back(mk("sh_4001", OP_SH, 64'h4001, 64'h1122, 64'h0, 0,
                      64'h4001, 8'h06, 64'h0011_2200, MSIZE2));
    vecs.push_back(mk("sw_wrap", OP_SW, 64'h0006, 64'hAABB_CCDD, 64'h0, 0,
                      64'h0006, 8'hC0, 64'hCCDD_0000_0000_0000, MSIZE4));
    vecs.push_back(mk("lw_wrap", OP_LW, 64'h0006, 64'h0, 64'hABCD_0000_0000_0000, 1,
                      64'hABCD, 8'h00, 64'h0, MSIZE4));
`endif

    // Reset state
    #12;
    chk("rst dreq_valid", 64'(dreq.valid), 64'd0);
    chk("rst dreq_addr", dreq.addr, 64'd0);
    chk("rst dreq_strobe", 64'(dreq.strobe), 64'd0);
    chk("rst dreq_data", dreq.data, 64'd0);
    chk("rst dataM_valid", 64'(dataM.valid), 64'd0);
    chk("rst dataM_result", dataM.result, 64'd0);
    chk("rst dataM_pc", dataM.pc, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst stopm", 64'(stopm), 64'd0);

    // Back-to-back pass-through
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (k > 0) begin
        chk("alu dataM_valid", 64'(dataM.valid), 64'd1);
        chk("alu dataM_result", dataM.result, 64'h1234 + 64'(k - 1));
      end
      if (k < 4) begin
        dataE        = '0;
        dataE.valid  = 1'b1;
        dataE.ctl.op = OP_ALU;
        dataE.result = 64'h1234 + 64'(k);
        #1;
        chk("alu stopm", 64'(stopm), 64'd0);
        chk("alu dreq_valid", 64'(dreq.valid), 64'd0);
      end else begin
        dataE.valid = 1'b0;
      end
    end

    // Directed table
    for (int i = 0; i < vecs.size(); i++)
      mem_op(vecs[i].nm, vecs[i].op, vecs[i].addr, vecs[i].rd2, vecs[i].rdata,
             vecs[i].nwait, vecs[i].exp_res, vecs[i].exp_strb, vecs[i].exp_wdata,
             vecs[i].exp_size);

    // Idle data_ok must be ignored
    @(posedge clk); #1;
    dresp.data_ok = 1'b1;
    dresp.data    = 64'hFFFF;
    @(negedge clk);
    chk("idle_ok dreq_valid", 64'(dreq.valid), 64'd0);
    @(posedge clk); #1;
    chk("idle_ok dataM_valid", 64'(dataM.valid), 64'd0);
    dresp = '0;

`ifdef MEM_MISALIGN_TRAP_EN
    @(posedge clk); #1;
    dataE        = '0;
    dataE.valid  = 1'b1;
    dataE.ctl.op = OP_LH;
    dataE.result = 64'h4001;
    @(negedge clk);
    chk("trap stopm", 64'(stopm), 64'd0);
    chk("trap dreq_valid", 64'(dreq.valid), 64'd0);
    @(posedge clk); #1;
    dataE.valid = 1'b0;
    chk("trap dataM_valid", 64'(dataM.valid), 64'd1);
    chk("trap dataM_result", dataM.result, 64'h4001);
    chk("trap flag", 64'(dataM.ctl.misalign), 64'd1);
    chk("trap dreq_after", 64'(dreq.valid), 64'd0);
`endif

    // Reset in the middle of a BUSY access
    @(posedge clk); #1;
    dataE        = '0;
    dataE.valid  = 1'b1;
    dataE.ctl.op = OP_LB;
    dataE.result = 64'h2001;
    @(posedge clk); #1;
    chk("rstbusy dreq_valid_before", 64'(dreq.valid), 64'd1);
    #2;
    reset       = 1'b1;
    dataE.valid = 1'b0;
    #1;
    chk("rstbusy dreq_valid", 64'(dreq.valid), 64'd0);
    chk("rstbusy dataM_valid", 64'(dataM.valid), 64'd0);
    chk("rstbusy stopm", 64'(stopm), 64'd0);
    @(posedge clk); #1;
    reset         = 1'b0;
    dresp.data_ok = 1'b1;
    dresp.data    = 64'h8000;
    @(negedge clk);
    chk("rstbusy late_ok dreq", 64'(dreq.valid), 64'd0);
    @(posedge clk); #1;
    chk("rstbusy late_ok dataM", 64'(dataM.valid), 64'd0);
    dresp        = '0;
    dataE        = '0;
    dataE.valid  = 1'b1;
    dataE.ctl.op = OP_ALU;
    dataE.result = 64'h55;
    @(posedge clk); #1;
    dataE.valid = 1'b0;
    chk("rstbusy add_valid", 64'(dataM.valid), 64'd1);
    chk("rstbusy add_result", dataM.result, 64'h55);

    // Randomized traffic against the byte-level model
    for (int r = 0; r < 40; r++) begin
      op_t         op    = ops[$urandom_range(0, 11)];
      logic [63:0] addr  = {$urandom, $urandom};
      logic [63:0] rd2   = {$urandom, $urandom};
      logic [63:0] rdata = {$urandom, $urandom};
      int          nw    = $urandom_range(0, 3);
      int          off;
`ifdef MEM_MISALIGN_TRAP_EN
      addr = addr & ~(64'(nbytes(op)) - 64'd1);
`endif
      off = int'(addr[2:0]);
      if (op == OP_ALU) begin
        @(posedge clk); #1;
        dataE        = '0;
        dataE.valid  = 1'b1;
        dataE.ctl.op = OP_ALU;
        dataE.result = addr;
        #1;
        chk("rnd alu stopm", 64'(stopm), 64'd0);
        @(posedge clk); #1;
        dataE.valid = 1'b0;
        chk("rnd alu result", dataM.result, addr);
        chk("rnd alu valid", 64'(dataM.valid), 64'd1);
      end else if (ref_is_load(op)) begin
        mem_op("rnd_load", op, addr, rd2, rdata, nw, ref_load(op, off, rdata),
               8'h00, 64'h0, ref_size(op));
      end else begin
        mem_op("rnd_store", op, addr, rd2, rdata, nw, addr,
               ref_strobe(op, off), ref_wdata(rd2, off), ref_size(op));
      end
    end

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/memory.md
# memory

Fourth stage of the five-stage RV64 in-order pipeline, between `execute` and `writeback`. Consumes `excute_data_t` from execute, performs loads and stores over the data bus with a per-access handshake, aligns and sign/zero-extends load data, and registers `memory_data_t` for writeback. Drives `stopm` to freeze execute (and everything upstream) while an access is outstanding.

## Interface
Parameters: none.
- `clk` in 1: pipeline clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `dataE` in `excute_data_t`: valid, pc, instr, ctl, dst, rd2 (store data), result (address or ALU result).
- `dreq` out `dbus_req_t`: valid, addr[63:0], size (`msize_t`), strobe[7:0], data[63:0].
- `dresp` in `dbus_resp_t`: data_ok, data[63:0].
- `dataM` out `memory_data_t`: valid, pc, instr, ctl, dst, result.
- `stopm` out 1: execute must hold `dataE` while high.

## Operation
- Classes by `dataE.ctl.op`: LOAD (LB/LH/LW/LD/LBU/LHU/LWU), STORE (SB/SH/SW/SD), other = pass-through.
- FSM states IDLE, BUSY.
  - IDLE, `dataE.valid` and LOAD/STORE: latch addr = `dataE.result`, size, strobe, shifted store data, load-extend kind; go BUSY; `stopm`=1; `dataM.valid`<=0.
  - IDLE, pass-through or invalid: `dataM` <= `dataE` fields, result = `dataE.result`, valid = `dataE.valid`; `stopm`=0.
  - BUSY: `dreq.valid`=1, all `dreq` fields from latches, stable until completion. `stopm` = !`dresp.data_ok`. On `data_ok`: `dataM` <= `dataE` fields, valid=1, result = extended load data (loads) or `dataE.result` (stores); go IDLE. Without `data_ok`: `dataM.valid`<=0.
- Store: strobe = size mask (0x01/0x03/0x0F/0xFF) << addr[2:0]; data = rd2 << (addr[2:0]*8); addr sent unmodified.
- Load: raw = `dresp.data` >> (addr[2:0]*8), then low 8/16/32/64 bits sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU); LD passes 64 bits. Load `dreq.strobe` = 0.
- `dresp.data_ok` in IDLE is ignored.
- `dreq.valid` never asserted in IDLE.

## Timing
- Reset (async): state IDLE; `dreq.valid`=0, `dreq` fields 0; `dataM` all 0 (valid=0); `stopm`=0 once reset deasserts with `dataE.valid`=0. Reset during BUSY abandons the access immediately; no `dataM` produced.
- Pass-through latency: 1 cycle, back-to-back every cycle.
- Memory latency: 1 cycle (IDLE->BUSY) + N BUSY cycles until `data_ok`; minimum 2 cycles, `dataM.valid` the edge `data_ok` is sampled.
- `stopm` combinational on state, `dataE`, `dresp.data_ok`; high from the IDLE cycle accepting a memory op through every BUSY cycle lacking `data_ok`; low in the completing cycle so execute advances on the same edge `dataM` is written.
- Back-to-back memory ops: second op enters IDLE the cycle after completion; no overlap, one outstanding access max.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined: a load/store whose addr is not size-aligned issues no bus request, stays IDLE, produces `dataM` in 1 cycle with valid=1, result = faulting address, `dataM.ctl` misalign flag set; `stopm`=0.
- Undefined: no alignment check; misaligned access issued as-is (strobe/shift may wrap past byte 7, upper lanes truncated); flag field absent/0.

## Structure
- Package `pipes`: `memory_data_t` (plus misalign flag under the macro), load-extend enum.
- Package `common`: `msize_t`, `dbus_req_t`, `dbus_resp_t`, `strobe_t`.
- Sub-module `mem_align`: combinational store strobe/data shift and load shift/extension; FSM and registers stay in `memory`.

## Test plan
- ADD pass-through, `dataE.result`=0x1234, valid=1 -> next cycle `dataM.result`=0x1234, valid=1, `stopm` never high.
- SB addr 0x1003, rd2=0xAB, `data_ok` in first BUSY cycle -> `dreq` strobe=0x08, data=0xAB000000, size=byte; `dataM.valid` 2 cycles after entry; `stopm` high exactly 1 cycle.
- LB addr 0x2001, dresp.data=0x0000_0000_0000_8000, `data_ok` after 3 BUSY cycles -> `dataM.result`=0xFFFF_FFFF_FFFF_FF80; LBU same -> 0x80; `dreq` fields stable all 3 cycles; `dataM.valid`=0 during wait.
- LW addr 0x3004, data 0x8000_0001_0000_0000 -> LW 0xFFFF_FFFF_8000_0001, LWU 0x8000_0001.
- Reset asserted in BUSY -> `dreq.valid` drops same cycle, `dataM.valid`=0, late `data_ok` ignored, following ADD passes normally.
- With `MEM_MISALIGN_TRAP_EN`: LH addr 0x4001 -> no `dreq.valid`, `dataM` next cycle with misalign flag=1, result=0x4001; without macro: `dreq` strobe=0x06.
